// File: rtl/instr_align_buffer_if.sv
// rtl/instr_align_buffer_if.sv - fetch, redirect and decode signal bundle for instr_align_buffer
interface instr_align_buffer_if;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_is_rvc;

    modport master (
        output fetch_pc, fetch_ready, dec_valid, dec_instr, dec_pc, dec_is_rvc,
        input  fetch_valid, fetch_data, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  fetch_pc, fetch_ready, dec_valid, dec_instr, dec_pc, dec_is_rvc,
        output fetch_valid, fetch_data, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/instr_align_buffer.sv
// rtl/instr_align_buffer.sv - halfword realignment buffer between instruction fetch and decode
// Define RVC_EN for 16-bit compressed support; the default build issues whole 32-bit words only.
module instr_align_buffer #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input logic                  clk,
    input logic                  rst,
    instr_align_buffer_if.master bus
);
`ifdef RVC_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif
    localparam int QW = 16 * DEPTH;

    logic [QW-1:0] q_r;
    logic [1:0]    count_r;
    logic [31:0]   head_pc_r;
    logic [31:0]   fetch_pc_r;

    logic [15:0]   hw0;
    logic [15:0]   hw1;
    logic          is32;
    logic          consume;
    logic          accept;
    logic          skip_hi;
    logic [1:0]    cons_n;
    logic [1:0]    remain;
    logic [1:0]    app_n;
    logic [1:0]    count_n;
    logic [31:0]   app_word;
    logic [63:0]   q_ext;
    logic [63:0]   kept;
    logic [63:0]   merged;
    logic [QW-1:0] q_n;
    logic [31:0]   redir_head;
    logic [31:0]   redir_fetch;
    logic [63-QW:0] unused_merged;

    assign hw0 = q_r[15:0];
    assign hw1 = q_r[31:16];

`ifdef RVC_EN
    typedef enum logic {RUN, SKIP_HI} state_t;
    state_t state_r, state_n;
    logic   unused_redirect_bits;

    always_ff @(posedge clk) begin
        if (rst) state_r <= RUN;
        else     state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        if (bus.redirect)
            state_n = bus.redirect_pc[1] ? SKIP_HI : RUN;
        else if (accept)
            state_n = RUN;
    end

    always_comb begin
        skip_hi = (state_r == SKIP_HI);
    end

    assign is32                 = (hw0[1:0] == 2'b11);
    assign redir_head           = {bus.redirect_pc[31:1], 1'b0};
    assign unused_redirect_bits = bus.redirect_pc[0];
`else
    logic [1:0] unused_redirect_bits;

    assign skip_hi              = 1'b0;
    assign is32                 = 1'b1;
    assign redir_head           = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = bus.redirect_pc[1:0];
`endif
    assign redir_fetch = {bus.redirect_pc[31:2], 2'b00};

    assign bus.dec_valid  = (count_r >= 2'd2) || ((count_r != 2'd0) && !is32);
    assign bus.dec_instr  = is32 ? {hw1, hw0} : {16'h0000, hw0};
    assign bus.dec_pc     = head_pc_r;
    assign bus.dec_is_rvc = ~is32;
    assign bus.fetch_pc   = fetch_pc_r;

    assign consume = bus.dec_valid && bus.dec_ready;
    assign cons_n  = !consume ? 2'd0 : (is32 ? 2'd2 : 2'd1);
    assign remain  = count_r - cons_n;

    // Ready only when the survivors plus a full word still fit in the queue.
    assign bus.fetch_ready = !bus.redirect && (remain <= 2'd1);
    assign accept          = bus.fetch_valid && bus.fetch_ready;

    // After a redirect into the upper half of a word, only that upper half enters the queue.
    assign app_word = !accept ? 32'h0 : (skip_hi ? {16'h0000, bus.fetch_data[31:16]} : bus.fetch_data);
    assign app_n    = !accept ? 2'd0 : (skip_hi ? 2'd1 : 2'd2);
    assign count_n  = remain + app_n;

    // Queue is packed with hw0 in the low bits: drop consumed entries, then append behind survivors.
    assign q_ext         = {{(64-QW){1'b0}}, q_r};
    assign kept          = (q_ext >> {cons_n, 4'b0000}) & ~({64{1'b1}} << {remain, 4'b0000});
    assign merged        = kept | ({32'h0, app_word} << {remain, 4'b0000});
    assign q_n           = merged[QW-1:0];
    assign unused_merged = merged[63:QW];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= '0;
            count_r    <= 2'd0;
            head_pc_r  <= RESET_VECTOR & ~32'h1;
            fetch_pc_r <= RESET_VECTOR & ~32'h3;
        end else if (bus.redirect) begin
            count_r    <= 2'd0;
            head_pc_r  <= redir_head;
            fetch_pc_r <= redir_fetch;
        end else begin
            q_r     <= q_n;
            count_r <= count_n;
            if (consume)
                head_pc_r <= head_pc_r + (is32 ? 32'd4 : 32'd2);
            if (accept)
                fetch_pc_r <= fetch_pc_r + 32'd4;
        end
    end
endmodule

// File: doc/instr_align_buffer.md
INSTR_ALIGN_BUFFER -- requirements
Module: instr_align_buffer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h8000_0000, fetch address after reset.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_pc  out  32  word-aligned address of next fetch, bits[1:0]=0
- fetch_valid  in  1  fetch_data valid for fetch_pc
- fetch_ready  out  1  buffer accepts fetch_data this cycle
- fetch_data  in  32  little-endian fetched word
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new PC, bit0 ignored
- dec_valid  out  1  dec_instr/dec_pc valid
- dec_ready  in  1  decoder consumes instruction
- dec_instr  out  32  aligned instruction, {16'b0,hw} when compressed
- dec_pc  out  32  PC of dec_instr
- dec_is_rvc  out  1  dec_instr is 16-bit
REQ-003 SHALL use only clk, with synchronous active-high rst, as already decided.

Function
REQ-004 SHALL hold a halfword queue of depth 3 (hw0 = oldest) with count 0..3 and head PC register head_pc.
REQ-005 SHALL classify hw0 as 32-bit when hw0[1:0]==2'b11, else 16-bit.
REQ-006 SHALL drive dec_valid=1 when (count>=1 and hw0 16-bit) or count>=2; combinational from registers only.
REQ-007 SHALL drive dec_instr={hw1,hw0} for 32-bit, {16'b0,hw0} for 16-bit; dec_pc=head_pc; dec_is_rvc=~(hw0[1:0]==2'b11).
REQ-008 Consume: dec_valid&&dec_ready removes 1 (16-bit) or 2 (32-bit) halfwords; head_pc advances by 2 or 4, mod 2^32 (wrap at 32'hFFFF_FFFE allowed).
REQ-009 SHALL drive fetch_ready=1 when (count - consumed_this_cycle) <= 1 and redirect=0; path from dec_ready is permitted.
REQ-010 Fetch: fetch_valid&&fetch_ready appends low halfword then high halfword behind remaining entries; fetch_pc advances by 4, mod 2^32.
REQ-011 Simultaneous consume and append in one cycle SHALL be supported; zero bubbles for back-to-back 32-bit or 16-bit streams when fetch_valid stays 1.
REQ-012 FSM states: RUN, SKIP_HI. SKIP_HI: next accepted fetch word appends only its high halfword, then -> RUN. RUN: normal append.
REQ-013 redirect=1 SHALL (priority over all else same cycle): count<=0; head_pc<={redirect_pc[31:1],1'b0}; fetch_pc<={redirect_pc[31:2],2'b00}; state<=SKIP_HI if redirect_pc[1] else RUN; any fetch data that cycle is discarded.
REQ-014 A dec handshake in a redirect cycle SHALL still count as issued; its buffer entries are flushed with the rest.
REQ-015 A 32-bit instruction whose second halfword is not yet buffered (count==1) SHALL hold dec_valid=0 until the next fetch lands.
REQ-016 dec_instr/dec_pc/dec_is_rvc SHALL remain stable while dec_valid=1 and dec_ready=0.

Reset
REQ-017 On rst: count=0, state=RUN, fetch_pc=RESET_VECTOR&~3, head_pc=RESET_VECTOR&~1, dec_valid=0, fetch_ready=1 (first cycle after rst deasserts).
REQ-018 rst asserted mid-stream SHALL discard all buffered halfwords with no output handshake.

Configuration
REQ-019 Macro RVC_EN defined: compressed support per REQ-004..018.
REQ-020 RVC_EN undefined: queue depth 2, every instruction 32-bit regardless of hw0[1:0], dec_is_rvc tied 0, SKIP_HI state removed, redirect_pc[1] treated as 0, head_pc advances by 4 only.

Verification
REQ-021 Reset, fetch 32'h0051_0113 at 0x8000_0000 -> dec_valid next cycle, dec_instr=32'h0051_0113, dec_pc=0x8000_0000, dec_is_rvc=0.
REQ-022 Fetch word 32'h4505_0505 (two RVC) -> two consecutive outputs 0x0000_0505 @0x8000_0000, 0x0000_4505 @0x8000_0002, dec_is_rvc=1.
REQ-023 Words 32'h0113_0505 then 32'hxxxx_0051 -> RVC 0x0505 @+0, then 32-bit 0x0051_0113 @+2 spanning the boundary.
REQ-024 redirect_pc=0x8000_0102 with buffer full -> fetch_pc=0x8000_0100, low halfword of next word dropped, first dec_pc=0x8000_0102.
REQ-025 dec_ready=0 for 5 cycles with fetch_valid=1 -> count saturates at 3, fetch_ready=0, outputs stable; release -> no lost/duplicated instruction.
REQ-026 RVC_EN undefined, fetch 32'h4505_0505 -> single output dec_instr=32'h4505_0505, dec_is_rvc=0, dec_pc advances by 4.
